// File: rtl/cu_pkg.sv
// Shared definitions for the sequencer control unit: state encodings,
// opcode class constants and the HALT operand fill value.
package cu_pkg;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } cu_state_e;

    // Opcode classes, matched against the leading opcode bits shown
    localparam logic       OP_ALU  = 1'b1;     // op[3]
    localparam logic [1:0] OP_CJMP = 2'b01;    // op[3:2]
    localparam logic [2:0] OP_MEM  = 3'b001;   // op[3:1]
    localparam logic [3:0] OP_JMP  = 4'b0000;  // op
    localparam logic [3:0] OP_NOP  = 4'b0001;  // op

    // HALT is OP_NOP with every operand bit equal to this value
    localparam logic HALT_OPND_FILL = 1'b1;

    // True for the memory opcode class (read in DECODE, ALU/write in EXECUTE)
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op[3:1] == OP_MEM);
    endfunction

endpackage

// File: rtl/seq_control_unit_if.sv
// Instruction/status inputs and control outputs of the sequencer.
// master: the control unit side; slave: the datapath side.
interface cu_if #(
    parameter int IW   = 12,
    parameter int SRW  = 4,
    parameter int LA_W = 8
);
    logic [IW-1:0]   insreg;
    logic [SRW-1:0]  statereg;
    logic            dm_ready;
    logic [3:0]      ALU_mode;
    logic            sel_MUX1;
    logic            sel_MUX2;
    logic            PC_E;
    logic            Acc_E;
    logic            SR_E;
    logic            IR_E;
    logic            DR_E;
    logic            PM_E;
    logic            PM_LE;
    logic            DM_E;
    logic            DM_WE;
    logic            ALU_E;
    logic [LA_W-1:0] load_addr;
    logic [2:0]      state_o;
    logic            halted;

    modport master (
        input  insreg, statereg, dm_ready,
        output ALU_mode, sel_MUX1, sel_MUX2, PC_E, Acc_E, SR_E, IR_E, DR_E,
               PM_E, PM_LE, DM_E, DM_WE, ALU_E, load_addr, state_o, halted
    );

    modport slave (
        output insreg, statereg, dm_ready,
        input  ALU_mode, sel_MUX1, sel_MUX2, PC_E, Acc_E, SR_E, IR_E, DR_E,
               PM_E, PM_LE, DM_E, DM_WE, ALU_E, load_addr, state_o, halted
    );
endinterface

// File: rtl/seq_control_unit_load_counter.sv
// Program-load address counter: advances while enabled, wraps to zero after
// the last program word and flags that terminal count.
module cu_load_counter #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic [AW-1:0] addr_o,
    output logic          tc_o
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;

    assign tc_o   = (addr_q == LAST);
    assign addr_o = addr_q;

    // Next address: hold, increment, or wrap after the last word
    always_comb begin
        addr_d = addr_q;
        if (en_i) begin
            if (tc_o) begin
                addr_d = '0;
            end else begin
                addr_d = addr_q + ONE;
            end
        end else begin
            addr_d = addr_q;
        end
    end

    // Address register, cleared by reset from any state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end
endmodule

// File: rtl/seq_control_unit.sv
// Sequencer control unit: LOAD -> FETCH -> DECODE -> EXECUTE loop with
// data-memory handshake stalls. Control outputs are decoded from the state
// register and the current inputs.
// Build option: define CU_HALT_EN to make op=0001 with an all-ones operand
// enter a HALT state that only reset leaves.
module seq_control_unit
    import cu_pkg::*;
#(
    parameter int IW         = 12,
    parameter int SRW        = 4,
    parameter int PROG_DEPTH = 256,
    parameter int LA_W       = $clog2(PROG_DEPTH)
) (
    input  logic clk,
    input  logic rst,
    cu_if.master bus
);
    localparam int SIW = $clog2(SRW);

    cu_state_e       state_q;
    logic [3:0]      op_s;
    logic [3:0]      f_s;
    logic [SIW-1:0]  sr_idx_s;
    logic            load_en_s;
    logic            load_tc_s;
    logic [LA_W-1:0] load_addr_s;
    logic            mem_op_s;

    assign op_s     = bus.insreg[IW-1:IW-4];
    assign f_s      = bus.insreg[IW-5:IW-8];
    assign mem_op_s = is_mem_op(op_s);

    // Status bit select is f modulo SRW; SRW is a power of two
    if (SIW <= 4) begin : g_idx_narrow
        assign sr_idx_s = f_s[SIW-1:0];
    end else begin : g_idx_wide
        assign sr_idx_s = {{(SIW-4){1'b0}}, f_s};
    end

`ifdef CU_HALT_EN
    logic halt_op_s;
    assign halt_op_s = (op_s == OP_NOP) &&
                       (bus.insreg[IW-5:0] == {(IW-4){HALT_OPND_FILL}});
`endif

    assign load_en_s = (state_q == S_LOAD) && !rst;

    cu_load_counter #(
        .DEPTH (PROG_DEPTH),
        .AW    (LA_W)
    ) u_load_counter (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (load_en_s),
        .addr_o (load_addr_s),
        .tc_o   (load_tc_s)
    );

    assign bus.load_addr = load_addr_s;
    assign bus.state_o   = state_q;

    // Sequencer state register with its transition rules
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (load_tc_s) state_q <= S_FETCH;
                    else           state_q <= S_LOAD;
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (mem_op_s && !bus.dm_ready) state_q <= S_DECODE;
                    else                           state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (mem_op_s && !op_s[0] && !bus.dm_ready) begin
                        state_q <= S_EXECUTE;
`ifdef CU_HALT_EN
                    end else if (halt_op_s) begin
                        state_q <= S_HALT;
`endif
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
`ifdef CU_HALT_EN
                S_HALT: begin
                    state_q <= S_HALT;
                end
`endif
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    // Control decode; everything not asserted by a rule stays 0, and reset
    // forces all controls low
    always_comb begin
        bus.ALU_mode = 4'h0;
        bus.sel_MUX1 = 1'b0;
        bus.sel_MUX2 = 1'b0;
        bus.PC_E     = 1'b0;
        bus.Acc_E    = 1'b0;
        bus.SR_E     = 1'b0;
        bus.IR_E     = 1'b0;
        bus.DR_E     = 1'b0;
        bus.PM_E     = 1'b0;
        bus.PM_LE    = 1'b0;
        bus.DM_E     = 1'b0;
        bus.DM_WE    = 1'b0;
        bus.ALU_E    = 1'b0;
        bus.halted   = 1'b0;
        if (rst) begin
            bus.ALU_mode = 4'h0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    bus.PM_LE = 1'b1;
                    bus.PM_E  = 1'b1;
                end
                S_FETCH: begin
                    bus.IR_E = 1'b1;
                    bus.PM_E = 1'b1;
                end
                S_DECODE: begin
                    if (mem_op_s) begin
                        bus.DM_E = 1'b1;
                        bus.DR_E = bus.dm_ready;
                    end else begin
                        bus.DM_E = 1'b0;
                    end
                end
                S_EXECUTE: begin
                    if (op_s[3] == OP_ALU) begin
                        bus.PC_E     = 1'b1;
                        bus.Acc_E    = 1'b1;
                        bus.SR_E     = 1'b1;
                        bus.ALU_E    = 1'b1;
                        bus.sel_MUX1 = 1'b1;
                        bus.ALU_mode = {1'b0, op_s[2:0]};
                    end else if (op_s[3:2] == OP_CJMP) begin
                        bus.PC_E     = 1'b1;
                        bus.sel_MUX1 = bus.statereg[sr_idx_s];
                    end else if (mem_op_s) begin
                        bus.ALU_E    = 1'b1;
                        bus.ALU_mode = f_s;
                        bus.sel_MUX1 = 1'b1;
                        bus.sel_MUX2 = 1'b1;
                        if (op_s[0]) begin
                            bus.Acc_E = 1'b1;
                            bus.PC_E  = 1'b1;
                            bus.SR_E  = 1'b1;
                        end else begin
                            // Write held until acknowledged; PC/SR fire once
                            bus.DM_E  = 1'b1;
                            bus.DM_WE = 1'b1;
                            bus.PC_E  = bus.dm_ready;
                            bus.SR_E  = bus.dm_ready;
                        end
                    end else if (op_s == OP_JMP) begin
                        bus.PC_E     = 1'b1;
                        bus.sel_MUX1 = 1'b1;
                    end else begin
`ifdef CU_HALT_EN
                        bus.PC_E = !halt_op_s;
`else
                        bus.PC_E = 1'b1;
`endif
                    end
                end
`ifdef CU_HALT_EN
                S_HALT: begin
                    bus.halted = 1'b1;
                end
`endif
                default: begin
                    bus.halted = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_control_unit.sv
// Scoreboard bench for seq_control_unit (IW=12, SRW=4, PROG_DEPTH=4).
// Stimulus pushes the hand-computed control word expected each cycle; the
// monitor pops and compares on the falling edge.
module tb_seq_control_unit;

    localparam int IW = 12;
    localparam int SRW = 4;
    localparam int PD = 4;
    localparam int LAW = 2;

    // Expected control word bits {PC,Acc,SR,IR,DR,PM,PMLE,DM,DMWE,ALU,S1,S2}
    localparam logic [11:0] C_PC   = 12'h800;
    localparam logic [11:0] C_ACC  = 12'h400;
    localparam logic [11:0] C_SR   = 12'h200;
    localparam logic [11:0] C_IR   = 12'h100;
    localparam logic [11:0] C_DR   = 12'h080;
    localparam logic [11:0] C_PME  = 12'h040;
    localparam logic [11:0] C_PMLE = 12'h020;
    localparam logic [11:0] C_DME  = 12'h010;
    localparam logic [11:0] C_DMWE = 12'h008;
    localparam logic [11:0] C_ALUE = 12'h004;
    localparam logic [11:0] C_S1   = 12'h002;
    localparam logic [11:0] C_S2   = 12'h001;
    localparam logic [11:0] C_NONE = 12'h000;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [11:0] ctl;
        logic [3:0]  mode;
        logic [1:0]  la;
        logic        hlt;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   n_cmp;
    int   n_bad;

    cu_if #(.IW(IW), .SRW(SRW), .LA_W(LAW)) bus ();

    seq_control_unit #(
        .IW(IW), .SRW(SRW), .PROG_DEPTH(PD), .LA_W(LAW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, %0d expectations pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    task automatic push(input string nm, input logic [2:0] st, input logic [11:0] c,
                        input logic [3:0] m, input logic [1:0] la, input logic h);
        exp_t e;
        e.name = nm; e.st = st; e.ctl = c; e.mode = m; e.la = la; e.hlt = h;
        sb_q.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq;
        for (int i = 0; i < PD; i++) begin
            push("load", 3'd0, C_PME | C_PMLE, 4'h0, 2'(i), 1'b0);
            step;
        end
    endtask

    task automatic fetch_cyc;
        push("fetch", 3'd1, C_IR | C_PME, 4'h0, 2'd0, 1'b0);
        step;
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [11:0] act;
            e = sb_q.pop_front();
            act = {bus.PC_E, bus.Acc_E, bus.SR_E, bus.IR_E, bus.DR_E, bus.PM_E,
                   bus.PM_LE, bus.DM_E, bus.DM_WE, bus.ALU_E, bus.sel_MUX1, bus.sel_MUX2};
            n_cmp++;
            if (act !== e.ctl || bus.ALU_mode !== e.mode || bus.state_o !== e.st ||
                bus.load_addr !== e.la || bus.halted !== e.hlt) begin
                n_bad++;
                $display("FAIL %s @%0t: got st=%0d ctl=%03h mode=%h la=%0d halted=%b, want st=%0d ctl=%03h mode=%h la=%0d halted=%b",
                         e.name, $time, bus.state_o, act, bus.ALU_mode, bus.load_addr, bus.halted,
                         e.st, e.ctl, e.mode, e.la, e.hlt);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.insreg = 12'h000;
        bus.statereg = 4'b0000;
        bus.dm_ready = 1'b0;
        step;
        step;
        push("rst_hold", 3'd0, C_NONE, 4'h0, 2'd0, 1'b0);
        step;
        rst = 1'b0;

        // Program load then first fetch
        load_seq;
        bus.insreg = 12'hA00;
        fetch_cyc;

        // ALU op 1010
        push("alu_dec", 3'd2, C_NONE, 4'h0, 2'd0, 1'b0);
        step;
        push("alu_exe", 3'd3, C_PC | C_ACC | C_SR | C_ALUE | C_S1, 4'h2, 2'd0, 1'b0);
        step;

        // Memory read + write with stalls
        bus.insreg = 12'h230;
        fetch_cyc;
        bus.dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push("mem_dec_stall", 3'd2, C_DME, 4'h0, 2'd0, 1'b0);
            step;
        end
        bus.dm_ready = 1'b1;
        push("mem_dec_ack", 3'd2, C_DME | C_DR, 4'h0, 2'd0, 1'b0);
        step;
        bus.dm_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push("mem_exe_stall", 3'd3, C_DME | C_DMWE | C_ALUE | C_S1 | C_S2, 4'h3, 2'd0, 1'b0);
            step;
        end
        bus.dm_ready = 1'b1;
        push("mem_exe_ack", 3'd3, C_DME | C_DMWE | C_ALUE | C_S1 | C_S2 | C_PC | C_SR, 4'h3, 2'd0, 1'b0);
        step;
        bus.dm_ready = 1'b0;

        // Memory read + ALU into accumulator, op 0011, f=5
        bus.insreg = 12'h350;
        fetch_cyc;
        bus.dm_ready = 1'b1;
        push("memacc_dec", 3'd2, C_DME | C_DR, 4'h0, 2'd0, 1'b0);
        step;
        bus.dm_ready = 1'b0;
        push("memacc_exe", 3'd3, C_ALUE | C_S1 | C_S2 | C_ACC | C_PC | C_SR, 4'h5, 2'd0, 1'b0);
        step;

        // Conditional jump on status bit 2 (f=6), taken then not taken
        bus.insreg = 12'h660;
        bus.statereg = 4'b0100;
        fetch_cyc;
        push("cjmp_dec", 3'd2, C_NONE, 4'h0, 2'd0, 1'b0);
        step;
        push("cjmp_taken", 3'd3, C_PC | C_S1, 4'h0, 2'd0, 1'b0);
        step;
        bus.statereg = 4'b0000;
        fetch_cyc;
        push("cjmp_dec2", 3'd2, C_NONE, 4'h0, 2'd0, 1'b0);
        step;
        push("cjmp_not_taken", 3'd3, C_PC, 4'h0, 2'd0, 1'b0);
        step;
        // f=0 selects bit 0, which is clear here
        bus.insreg = 12'h600;
        bus.statereg = 4'b0100;
        fetch_cyc;
        push("cjmp_f0_dec", 3'd2, C_NONE, 4'h0, 2'd0, 1'b0);
        step;
        push("cjmp_f0_exe", 3'd3, C_PC, 4'h0, 2'd0, 1'b0);
        step;

        // Unconditional jump and NOP
        bus.insreg = 12'h000;
        fetch_cyc;
        push("jmp_dec", 3'd2, C_NONE, 4'h0, 2'd0, 1'b0);
        step;
        push("jmp_exe", 3'd3, C_PC | C_S1, 4'h0, 2'd0, 1'b0);
        step;
        bus.insreg = 12'h123;
        fetch_cyc;
        push("nop_dec", 3'd2, C_NONE, 4'h0, 2'd0, 1'b0);
        step;
        push("nop_exe", 3'd3, C_PC, 4'h0, 2'd0, 1'b0);
        step;

        // Reset during an EXECUTE write stall
        bus.insreg = 12'h230;
        fetch_cyc;
        bus.dm_ready = 1'b1;
        push("stall_dec", 3'd2, C_DME | C_DR, 4'h0, 2'd0, 1'b0);
        step;
        bus.dm_ready = 1'b0;
        push("stall_exe", 3'd3, C_DME | C_DMWE | C_ALUE | C_S1 | C_S2, 4'h3, 2'd0, 1'b0);
        step;
        rst = 1'b1;
        push("rst_in_stall", 3'd3, C_NONE, 4'h0, 2'd0, 1'b0);
        step;
        rst = 1'b0;
        load_seq;

        // HALT encoding
        bus.insreg = 12'h1FF;
        fetch_cyc;
        push("halt_dec", 3'd2, C_NONE, 4'h0, 2'd0, 1'b0);
        step;
`ifdef CU_HALT_EN
        push("halt_exe", 3'd3, C_NONE, 4'h0, 2'd0, 1'b0);
        step;
        for (int i = 0; i < 10; i++) begin
            push("halted", 3'd4, C_NONE, 4'h0, 2'd0, 1'b1);
            step;
        end
        rst = 1'b1;
        push("rst_in_halt", 3'd4, C_NONE, 4'h0, 2'd0, 1'b0);
        step;
        rst = 1'b0;
        load_seq;
        fetch_cyc;
`else
        push("halt_as_nop", 3'd3, C_PC, 4'h0, 2'd0, 1'b0);
        step;
        fetch_cyc;
`endif

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
